// File: rtl/bht_access_scheduler.sv
// Single-port 2-bit branch counter table shared by lookups and buffered updates.
// Optional BHT_STALL_CNT_EN adds a saturating lookup-stall counter output.
module bht_access_scheduler #(
  parameter int NUM_ENTRIES  = 1024,
  parameter int IDX_W        = $clog2(NUM_ENTRIES),
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        lookup_valid,
  input  logic [IDX_W-1:0]            lookup_index,
  output logic                        lookup_ready,
  output logic                        pred_valid,
  output logic                        pred_taken,
  output logic [1:0]                  pred_counter,
  input  logic                        upd_valid,
  input  logic [IDX_W-1:0]            upd_index,
  input  logic                        upd_taken,
  output logic                        upd_ready,
  output logic                        init_done,
`ifdef BHT_STALL_CNT_EN
  output logic [15:0]                 stall_count,
`endif
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(FIFO_DEPTH);
  localparam logic [SC_W-1:0]  STARVE_MAX = SC_W'(STARVE_LIMIT);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_ENTRIES - 1);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_e;

  state_e state_q, state_d;
  logic [IDX_W-1:0] init_ptr_q, init_ptr_d;

  logic [1:0] mem_q [NUM_ENTRIES];

  logic [IDX_W-1:0] fifo_idx_q [FIFO_DEPTH];
  logic             fifo_tkn_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SC_W-1:0]  starve_q, starve_d;

  logic       pred_valid_q;
  logic [1:0] pred_cnt_q;

  logic             run;
  logic             fifo_full;
  logic             fifo_empty;
  logic             must_drain;
  logic             do_lookup;
  logic             do_drain;
  logic             push;
  logic [IDX_W-1:0] head_idx;
  logic             head_tkn;
  logic [IDX_W-1:0] mem_addr;
  logic [1:0]       rd_cnt;
  logic [1:0]       upd_cnt;
  logic             mem_we;
  logic [IDX_W-1:0] mem_waddr;
  logic [1:0]       mem_wdata;

  assign run        = (state_q == S_RUN);
  assign fifo_full  = (cnt_q == FULL_CNT);
  assign fifo_empty = (cnt_q == '0);

  // Full FIFO or a starved head preempts the front end for one cycle.
  assign must_drain = run && (fifo_full || starve_q == STARVE_MAX);

  assign lookup_ready = run && !must_drain;
  assign upd_ready    = run && !fifo_full;
  assign init_done    = run;
  assign fifo_count   = cnt_q;

  assign do_lookup = lookup_valid && lookup_ready;
  assign do_drain  = must_drain ||
                     (run && !lookup_valid && !fifo_empty);
  assign push      = upd_valid && upd_ready;

  assign head_idx = fifo_idx_q[rd_ptr_q];
  assign head_tkn = fifo_tkn_q[rd_ptr_q];

  assign mem_addr = do_drain ? head_idx : lookup_index;
  assign rd_cnt   = mem_q[mem_addr];

  always_comb begin
    upd_cnt = rd_cnt;
    if (head_tkn) begin
      if (rd_cnt != 2'd3) upd_cnt = rd_cnt + 2'd1;
    end else begin
      if (rd_cnt != 2'd0) upd_cnt = rd_cnt - 2'd1;
    end
  end

  assign mem_we    = !run || do_drain;
  assign mem_waddr = run ? head_idx : init_ptr_q;
  assign mem_wdata = run ? upd_cnt : 2'b00;

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    unique case (state_q)
      S_INIT: begin
        init_ptr_d = init_ptr_q + IDX_W'(1);
        if (init_ptr_q == LAST_IDX) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        state_d = S_RUN;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    starve_d = starve_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (do_drain) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({push, do_drain})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    if (do_drain || fifo_empty) begin
      starve_d = '0;
    end else begin
      starve_d = starve_q + SC_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_idx_q[wr_ptr_q] <= upd_index;
      fifo_tkn_q[wr_ptr_q] <= upd_taken;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_INIT;
      init_ptr_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      starve_q     <= '0;
      pred_valid_q <= 1'b0;
      pred_cnt_q   <= 2'b00;
    end else begin
      state_q      <= state_d;
      init_ptr_q   <= init_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      starve_q     <= starve_d;
      pred_valid_q <= do_lookup;
      if (do_lookup) begin
        pred_cnt_q <= rd_cnt;
      end
    end
  end

  assign pred_valid   = pred_valid_q;
  assign pred_counter = pred_cnt_q;
  assign pred_taken   = pred_cnt_q[1];

`ifdef BHT_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q <= '0;
    end else if (run && lookup_valid && !lookup_ready &&
                 stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_bht_access_scheduler.sv
// Randomised bench for bht_access_scheduler against a queue-based model.
// Directed sequences cover init, saturation, full FIFO, starvation and reset.
module tb_bht_access_scheduler;

  localparam int N  = 16;
  localparam int IW = 4;
  localparam int FD = 4;
  localparam int SL = 8;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset;
  logic          lookup_valid;
  logic [IW-1:0] lookup_index;
  logic          lookup_ready;
  logic          pred_valid;
  logic          pred_taken;
  logic [1:0]    pred_counter;
  logic          upd_valid;
  logic [IW-1:0] upd_index;
  logic          upd_taken;
  logic          upd_ready;
  logic          init_done;
  logic [2:0]    fifo_count;
`ifdef BHT_STALL_CNT_EN
  logic [15:0]   stall_count;
`endif

  bht_access_scheduler #(
    .NUM_ENTRIES (N),
    .FIFO_DEPTH  (FD),
    .STARVE_LIMIT(SL)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .lookup_valid(lookup_valid),
    .lookup_index(lookup_index),
    .lookup_ready(lookup_ready),
    .pred_valid  (pred_valid),
    .pred_taken  (pred_taken),
    .pred_counter(pred_counter),
    .upd_valid   (upd_valid),
    .upd_index   (upd_index),
    .upd_taken   (upd_taken),
    .upd_ready   (upd_ready),
    .init_done   (init_done),
`ifdef BHT_STALL_CNT_EN
    .stall_count (stall_count),
`endif
    .fifo_count  (fifo_count)
  );

  int n_tests;
  int n_fail;

  int m_tab [N];
  int q_idx [$];
  bit q_tkn [$];
  int m_init;
  int m_starve;
  bit m_pv;
  int m_pc;
  int m_stall;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs();
    bit run;
    bit must;
    run  = (m_init == 0);
    must = (q_idx.size() == FD) || (m_starve == SL);
    chk("init_done", 32'(init_done), 32'(run));
    chk("lookup_ready", 32'(lookup_ready), 32'(run && !must));
    chk("upd_ready", 32'(upd_ready), 32'(run && q_idx.size() < FD));
    chk("fifo_count", 32'(fifo_count), 32'(q_idx.size()));
    chk("pred_valid", 32'(pred_valid), 32'(m_pv));
    if (m_pv) begin
      chk("pred_counter", 32'(pred_counter), 32'(m_pc));
      chk("pred_taken", 32'(pred_taken), 32'(m_pc >= 2));
    end
`ifdef BHT_STALL_CNT_EN
    chk("stall_count", 32'(stall_count), 32'(m_stall));
`endif
  endtask

  task automatic model_step(input bit r, input bit lv, input int li,
                            input bit uv, input int ui, input bit ut);
    int  sz;
    bit  must;
    bit  drained;
    int  h;
    bit  t;
    if (r) begin
      m_init   = N;
      m_starve = 0;
      m_pv     = 0;
      m_pc     = 0;
      m_stall  = 0;
      q_idx.delete();
      q_tkn.delete();
      foreach (m_tab[i]) m_tab[i] = 0;
      return;
    end
    if (m_init > 0) begin
      m_init--;
      m_pv = 0;
      return;
    end
    sz      = q_idx.size();
    must    = (sz == FD) || (m_starve == SL);
    drained = 0;
    m_pv    = 0;
    if (must || (!lv && sz > 0)) begin
      h = q_idx.pop_front();
      t = q_tkn.pop_front();
      if (t) m_tab[h] = (m_tab[h] == 3) ? 3 : m_tab[h] + 1;
      else   m_tab[h] = (m_tab[h] == 0) ? 0 : m_tab[h] - 1;
      drained = 1;
    end else if (lv) begin
      m_pv = 1;
      m_pc = m_tab[li];
    end
    if (lv && must && m_stall < 65535) m_stall++;
    m_starve = (drained || sz == 0) ? 0 : m_starve + 1;
    if (uv && sz < FD) begin
      q_idx.push_back(ui);
      q_tkn.push_back(ut);
    end
  endtask

  task automatic cycle(input bit r, input bit lv, input int li,
                       input bit uv, input int ui, input bit ut);
    @(negedge clock);
    check_outs();
    reset        = r;
    lookup_valid = lv;
    lookup_index = li[IW-1:0];
    upd_valid    = uv;
    upd_index    = ui[IW-1:0];
    upd_taken    = ut;
    model_step(r, lv, li, uv, ui, ut);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    reset        = 1'b1;
    lookup_valid = 1'b0;
    lookup_index = '0;
    upd_valid    = 1'b0;
    upd_index    = '0;
    upd_taken    = 1'b0;
    model_step(1, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clock);

    // init window with lookups requested; then read back every entry
    for (int i = 0; i < 20; i++) cycle(0, 1, i % N, 1, 5, 1);
    idle(6);
    for (int i = 0; i < N; i++) cycle(0, 1, i, 0, 0, 0);

    // saturate idx 3 upwards, then to the floor
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 3, 1);
    idle(5);
    cycle(0, 1, 3, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 3, 0);
    idle(6);
    cycle(0, 1, 3, 0, 0, 0);
    idle(2);

    // fill the FIFO behind continuous lookups
    for (int i = 0; i < 4; i++) cycle(0, 1, 7, 1, 7, 1);
    for (int i = 0; i < 6; i++) cycle(0, 1, 7, 0, 0, 0);
    idle(6);

    // single update starved by continuous lookups
    cycle(0, 1, 9, 1, 9, 1);
    for (int i = 0; i < 14; i++) cycle(0, 1, 9, 0, 0, 0);
    idle(3);

    // reset with three pending updates and a prediction in flight
    for (int i = 0; i < 3; i++) cycle(0, 1, 2, 1, 2, 1);
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) cycle(0, 1, 2, 0, 0, 0);

    // randomised traffic with occasional reset
    for (int i = 0; i < 4000; i++) begin
      int li;
      int ui;
      li = ($urandom_range(0, 3) == 0) ? $urandom_range(0, N - 1)
                                       : $urandom_range(0, 3);
      ui = ($urandom_range(0, 3) == 0) ? $urandom_range(0, N - 1)
                                       : $urandom_range(0, 3);
      cycle($urandom_range(0, 599) == 0,
            $urandom_range(0, 9) < 7, li,
            $urandom_range(0, 9) < 4, ui,
            $urandom_range(0, 2) != 0);
    end
    idle(10);
    for (int i = 0; i < N; i++) cycle(0, 1, i, 0, 0, 0);
    idle(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
